// File: rtl/pipelined_addsub_pkg.sv
// Shared types, opcodes and flag helper for the pipelined adder/subtractor.
package addsub_pkg;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } addsub_flags_t;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic addsub_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_addsub_chunk.sv
// Combinational CHUNK-bit slice adder used once per pipeline stage.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub, one CHUNK slice per stage, valid/ready with backpressure.
// Optional signed saturation on overflow: `define PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    addsub_flags_t    flags_q;

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = flags_q.carry;
    assign bus.overflow  = flags_q.overflow;
    assign bus.zero      = flags_q.zero;

    // Stage k sees only the operand bits not yet consumed (a_in/b_in shrink
    // by CHUNK per stage) and grows the finished low result bits in s_nxt.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int IW = WIDTH - LO;

        logic [IW-1:0]       a_in;
        logic [IW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [CHUNK-1:0]    csum;
        logic                cout;
        logic [LO+CHUNK-1:0] s_nxt;

        if (k == 0) begin : g_head
            assign a_in  = bus.x;
            assign b_in  = bus.y ^ {WIDTH{bus.sub}};
            assign c_in  = (bus.sub == ADDSUB_OP_SUB);
            assign v_in  = bus.in_valid;
            assign s_nxt = csum;
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_fwd.x_q;
            assign b_in  = g_stage[k-1].g_fwd.y_q;
            assign c_in  = g_stage[k-1].g_fwd.c_q;
            assign v_in  = g_stage[k-1].g_fwd.v_q;
            assign s_nxt = {csum, g_stage[k-1].g_fwd.s_q};
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .cin  (c_in),
            .sum  (csum),
            .cout (cout)
        );

        if (k < STAGES - 1) begin : g_fwd
            logic                v_q;
            logic [IW-CHUNK-1:0] x_q;
            logic [IW-CHUNK-1:0] y_q;
            logic [LO+CHUNK-1:0] s_q;
            logic                c_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    y_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_in;
                    x_q <= a_in[IW-1:CHUNK];
                    y_q <= b_in[IW-1:CHUNK];
                    s_q <= s_nxt;
                    c_q <= cout;
                end
            end
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] res;
            addsub_flags_t    flags_d;

            always_comb begin
                ovf = addsub_ovf(a_in[CHUNK-1], b_in[CHUNK-1], s_nxt[WIDTH-1]);
                res = s_nxt;
`ifdef PIPELINED_ADDSUB_SAT_EN
                if (ovf) begin
                    res = a_in[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                flags_d.carry    = cout;
                flags_d.overflow = ovf;
                flags_d.zero     = (res == '0);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    result_q    <= '0;
                    flags_q     <= '0;
                end else if (adv) begin
                    out_valid_q <= v_in;
                    result_q    <= res;
                    flags_q     <= flags_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4); honours PIPELINED_ADDSUB_SAT_EN.
module tb_pipelined_addsub;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    typedef struct {
        bit          v;
        logic [15:0] res;
        bit          c;
        bit          o;
        bit          z;
    } slot_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    slot_t pipe [STAGES];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference: plain integer arithmetic on the operands' true values.
    function automatic slot_t ref_op(input logic [15:0] a, input logic [15:0] b, input bit s);
        slot_t e;
        int ia, ib, r, ua, ub;
        ia = int'($signed(a));
        ib = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = s ? ia - ib : ia + ib;
        e.v   = 1'b1;
        e.o   = (r > 32767) || (r < -32768);
        e.c   = s ? (ua >= ub) : (ua + ub > 65535);
        e.res = 16'(r);
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (e.o) e.res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z = (e.res == 16'h0000);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_cleared();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_carry", bus.carry, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_in_ready", bus.in_ready, 1);
    endtask

    // One clock: drive at negedge, check pre-edge outputs, advance the model.
    task automatic cycle(input bit r, input bit iv, input logic [15:0] xi,
                         input logic [15:0] yi, input bit si, input bit ordy);
        bit    adv;
        slot_t e;
        rst = r; bus.in_valid = iv; bus.x = xi; bus.y = yi; bus.sub = si; bus.out_ready = ordy;
        #1;
        adv = !pipe[STAGES-1].v || ordy;
        chk("in_ready", bus.in_ready, adv);
        chk("out_valid", bus.out_valid, pipe[STAGES-1].v);
        if (pipe[STAGES-1].v) begin
            chk("result", bus.result, pipe[STAGES-1].res);
            chk("carry", bus.carry, pipe[STAGES-1].c);
            chk("overflow", bus.overflow, pipe[STAGES-1].o);
            chk("zero", bus.zero, pipe[STAGES-1].z);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < STAGES; i++) pipe[i].v = 1'b0;
        end else if (adv) begin
            for (int i = STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
            e = ref_op(xi, yi, si);
            e.v = iv;
            pipe[0] = e;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [6];
        edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        if ($urandom_range(3) == 0) return edges[$urandom_range(5)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] dx [9];
        logic [15:0] dy [9];
        bit          ds [9];
        int          lat;

        dx = '{16'h1234, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
        dy = '{16'h0FFF, 16'h0007, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h8000};
        ds = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < STAGES; i++) pipe[i].v = 1'b0;

        rst = 1'b1; bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_cleared();

        // Directed corner operations, back to back.
        for (int i = 0; i < 9; i++) cycle(0, 1, dx[i], dy[i], ds[i], 1);
        repeat (6) cycle(0, 0, 16'h0, 16'h0, 0, 1);

        // Accept-to-valid latency counted in cycles including the accept cycle.
        lat = 0;
        cycle(0, 1, 16'h1234, 16'h0FFF, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 16'h0, 16'h0, 0, 1);
            if (bus.out_valid === 1'b1 && lat == 0) lat = i + 1;
        end
        chk("latency", lat, STAGES);

        // Eight back-to-back ops.
        for (int i = 0; i < 8; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 1);
        repeat (6) cycle(0, 0, 16'h0, 16'h0, 0, 1);

        // Backpressure for three cycles mid-stream.
        for (int i = 0; i < 6; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 1);
        repeat (6) cycle(0, 0, 16'h0, 16'h0, 0, 1);

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++)
            cycle(0, 1'($urandom_range(3) != 0), pick(), pick(), 1'($urandom), $urandom_range(3) != 0);
        repeat (8) cycle(0, 0, 16'h0, 16'h0, 0, 1);

        // Reset with three ops in flight, then make sure nothing stale emerges.
        for (int i = 0; i < 3; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 1);
        cycle(1, 0, 16'h0, 16'h0, 0, 1);
        #1;
        chk_cleared();
        repeat (8) cycle(0, 0, 16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, pick(), pick(), 1'($urandom), 1);
        repeat (6) cycle(0, 0, 16'h0, 16'h0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
